mem_arbiter_rr: RTL and testbench

- Parametrised N-port line-level memory arbiter between cache-side requesters (I-cache, D-cache, prefetcher, etc.) and a single downstream line port, normally the cacheline burst adaptor.
- Generalises the two-port I/D arbiter in three ways:
  - arbitrary port count;
  - parametrised line and address widths;
  - registered request capture with fair round-robin grant.
- Starvation-free: every pending port is served within NUM_PORTS transactions.

---
 rtl/mem_arbiter_rr.sv | 160 ++++++++++++++++
 tb/tb_mem_arbiter_rr.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_rr.sv
// N-port line-level memory arbiter: registered request capture, round-robin grant, single downstream line port.
// Define MEM_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority (no last-grant pointer).
module mem_arbiter_rr #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int LINE_W    = 256
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS-1:0]        req_read,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [NUM_PORTS*LINE_W-1:0] req_wdata,
  output logic [LINE_W-1:0]           req_rdata,
  output logic [NUM_PORTS-1:0]        req_resp,
  output logic [NUM_PORTS-1:0]        grant,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [LINE_W-1:0]           mem_wdata,
  input  logic [LINE_W-1:0]           mem_rdata,
  input  logic                        mem_resp
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e                 state_q, state_d;
  logic [NUM_PORTS-1:0]   grant_q, grant_d;
  logic                   mem_read_q, mem_read_d;
  logic                   mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [LINE_W-1:0]      wdata_q, wdata_d;
  logic [LINE_W-1:0]      rdata_q, rdata_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]       last_q, last_d;
`endif

  logic [NUM_PORTS-1:0]   pending;
  logic                   win_found;
  logic [IDX_W-1:0]       win_idx;

  assign pending = req_read | req_write;

  // Winner search. Round-robin splits the pending set into ports above the
  // last grant (preferred, lowest first) and the wrap-around remainder.
  always_comb begin
    logic             lo_found;
    logic [IDX_W-1:0] lo_idx;
`ifndef MEM_ARB_FIXED_PRIO_EN
    logic             hi_found;
    logic [IDX_W-1:0] hi_idx;
    hi_found = 1'b0;
    hi_idx   = '0;
`endif
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (pending[i]) begin
`ifndef MEM_ARB_FIXED_PRIO_EN
        if (i > int'(last_q)) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(i);
        end
`endif
        lo_found = 1'b1;
        lo_idx   = IDX_W'(i);
      end
    end
    win_found = lo_found;
`ifndef MEM_ARB_FIXED_PRIO_EN
    win_idx   = hi_found ? hi_idx : lo_idx;
`else
    win_idx   = lo_idx;
`endif
  end

  always_comb begin
    // NOTE: every _d signal gets its hold value first so no path can infer a latch.
    state_d     = state_q;
    grant_d     = grant_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
    last_d      = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d     = NUM_PORTS'(1) << win_idx;
          addr_d      = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
          wdata_d     = req_wdata[int'(win_idx)*LINE_W +: LINE_W];
          mem_read_d  = req_read[win_idx];
          mem_write_d = ~req_read[win_idx] & req_write[win_idx];
`ifndef MEM_ARB_FIXED_PRIO_EN
          last_d      = win_idx;
`endif
          state_d     = BUSY;
        end
      end
      BUSY: begin
        // Requester inputs are deliberately not looked at here.
        if (mem_resp) begin
          rdata_d     = mem_rdata;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = RESP;
        end
      end
      RESP: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      // NOTE: the line-wide datapath registers are reset because their zero
      // value is visible on the ports straight out of reset.
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_q      <= IDX_W'(NUM_PORTS - 1);
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_q      <= last_d;
`endif
    end
  end

  assign req_resp  = (state_q == RESP) ? grant_q : '0;
  assign grant     = grant_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign req_rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Scoreboard bench for mem_arbiter_rr (3 ports): directed scenarios plus randomized traffic against
// a queue-based arbitration model. Honours MEM_ARB_FIXED_PRIO_EN in the model.
module tb_mem_arbiter_rr;

  localparam int NP = 3;
  localparam int AW = 32;
  localparam int LW = 256;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP*AW-1:0]  req_addr;
  logic [NP-1:0]     req_read, req_write;
  logic [NP*LW-1:0]  req_wdata;
  logic [LW-1:0]     req_rdata;
  logic [NP-1:0]     req_resp, grant;
  logic [AW-1:0]     mem_addr;
  logic              mem_read, mem_write;
  logic [LW-1:0]     mem_wdata, mem_rdata;
  logic              mem_resp;

  mem_arbiter_rr #(.NUM_PORTS(NP), .ADDR_W(AW), .LINE_W(LW)) dut (
    .clk       (clk),
    .reset_n   (rst_n),
    .req_addr  (req_addr),
    .req_read  (req_read),
    .req_write (req_write),
    .req_wdata (req_wdata),
    .req_rdata (req_rdata),
    .req_resp  (req_resp),
    .grant     (grant),
    .mem_addr  (mem_addr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_resp  (mem_resp)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model and scoreboard ----------------
  typedef struct {
    int          port;
    logic        is_read;
    logic [LW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [NP-1:0] grant_log[$];
  int            model_last = NP - 1;

  int            cur_port;
  logic          cur_read, cur_write;
  logic [AW-1:0] cur_addr;
  logic [LW-1:0] cur_wdata;

  // Requester inputs as seen at the most recent rising edge.
  logic [NP-1:0]    pend_s, rd_s, wr_s;
  logic [NP*AW-1:0] addr_s;
  logic [NP*LW-1:0] wdata_s;
  logic             mresp_edge;

  always @(posedge clk) begin
    pend_s     <= req_read | req_write;
    rd_s       <= req_read;
    wr_s       <= req_write;
    addr_s     <= req_addr;
    wdata_s    <= req_wdata;
    mresp_edge <= mem_resp;
  end

  function automatic int pick(input logic [NP-1:0] p, input int last);
`ifdef MEM_ARB_FIXED_PRIO_EN
    for (int k = 0; k < NP; k++) if (p[k]) return k;
`else
    for (int k = 1; k <= NP; k++) begin
      int i;
      i = (last + k) % NP;
      if (p[i]) return i;
    end
`endif
    return -1;
  endfunction

  logic op_prev = 1'b0;

  always @(negedge clk) begin
    logic          op_now;
    int            w;
    logic [NP-1:0] exp_g;
    exp_t          e;
    if (!rst_n) begin
      sb.delete();
      model_last = NP - 1;
      op_prev    = 1'b0;
    end else begin
      op_now = mem_read | mem_write;
      if (op_now && !op_prev) begin
        w = pick(pend_s, model_last);
        if (w < 0) begin
          check("start_without_request", {mem_read, mem_write}, '0);
        end else begin
          exp_g     = NP'(1) << w;
          cur_port  = w;
          cur_read  = rd_s[w];
          cur_write = ~rd_s[w] & wr_s[w];
          cur_addr  = addr_s[w*AW +: AW];
          cur_wdata = wdata_s[w*LW +: LW];
          check("start_grant", grant, exp_g);
          check("start_op", {mem_read, mem_write}, {cur_read, cur_write});
          check("start_addr", mem_addr, cur_addr);
          check("start_wdata", mem_wdata, cur_wdata);
          model_last = w;
          grant_log.push_back(grant);
        end
      end else if (op_now) begin
        check("busy_hold_op_addr", {mem_read, mem_write, mem_addr}, {cur_read, cur_write, cur_addr});
        check("busy_hold_wdata", mem_wdata, cur_wdata);
      end
      if (req_resp != '0) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", req_resp, '0);
        end else begin
          e = sb.pop_front();
          check("resp_port", req_resp, NP'(1) << e.port);
          if (e.is_read) check("resp_rdata", req_rdata, e.data);
        end
      end
      op_prev = op_now;
    end
  end

  // ---------------- downstream memory responder ----------------
  logic mem_auto    = 1'b0;
  int   resp_lat    = 0;
  logic rdata_fixed = 1'b0;

  initial begin
    int lat;
    mem_resp  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      if (mem_auto && rst_n && (mem_read || mem_write)) begin
        lat = (resp_lat > 0) ? resp_lat : $urandom_range(1, 5);
        for (int k = 1; k < lat; k++) begin
          @(negedge clk);
          #1;
        end
        if (rst_n && (mem_read || mem_write)) begin
          mem_rdata = rdata_fixed ? {32{8'hA5}} : {8{$urandom()}};
          mem_resp  = 1'b1;
          sb.push_back('{port: cur_port, is_read: cur_read, data: mem_rdata});
          @(negedge clk);
          #1;
          mem_resp = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_resp(input int p, input string nm);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (req_resp[p]) return;
    end
    check(nm, req_resp[p], 1'b1);
  endtask

  task automatic wait_grant_write(input int p, input string nm);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (grant[p] && mem_write) return;
    end
    check(nm, {grant[p], mem_write}, 2'b11);
  endtask

  logic [NP-1:0] active;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks, expected completion", n_checks);
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    req_addr  = '0;
    req_read  = '0;
    req_write = '0;
    req_wdata = '0;
    active    = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_ctrl", {grant, req_resp, mem_read, mem_write}, '0);
    check("rst_addr", mem_addr, '0);
    check("rst_wdata", mem_wdata, '0);
    check("rst_rdata", req_rdata, '0);
    #2 rst_n = 1'b1;

    // Single port read, 4-cycle downstream latency.
    mem_auto = 1'b1; resp_lat = 4; rdata_fixed = 1'b1;
    @(negedge clk);
    req_addr[0 +: AW] = 32'h0000_1000;
    req_read[0]       = 1'b1;
    @(negedge clk);
    check("t1_mem_read_next_cycle", mem_read, 1'b1);
    check("t1_mem_addr", mem_addr, 32'h0000_1000);
    begin
      bit seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        if (mresp_edge) seen = 1;
      end
      check("t1_resp_after_mem_resp", req_resp, 3'b001);
      check("t1_rdata", req_rdata, {32{8'hA5}});
    end
    req_read[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("t1_grant_idle", grant, '0);
    check("t1_resp_one_pulse", req_resp, '0);
    rdata_fixed = 1'b0;

    // Port 1 write queued behind port 0 read; changes during its BUSY ignored.
    @(negedge clk);
    req_addr[0 +: AW] = 32'h0000_3000;
    req_read[0]       = 1'b1;
    @(negedge clk);
    req_addr[AW +: AW] = 32'h0000_2000;
    req_wdata[LW +: LW] = LW'(32'h1234);
    req_write[1]       = 1'b1;
    wait_resp(0, "t3_port0_resp");
    req_read[0] = 1'b0;
    wait_grant_write(1, "t3_port1_write_start");
    check("t3_op", {mem_read, mem_write}, 2'b01);
    check("t3_addr", mem_addr, 32'h0000_2000);
    check("t3_wdata", mem_wdata, LW'(32'h1234));
    req_addr[AW +: AW]  = 32'h0000_BAD0;
    req_wdata[LW +: LW] = '1;
    @(negedge clk);
    check("t3_addr_hold", mem_addr, 32'h0000_2000);
    check("t3_wdata_hold", mem_wdata, LW'(32'h1234));
    wait_resp(1, "t3_port1_resp");
    req_write[1] = 1'b0;

    // Read and write together: read wins.
    @(negedge clk);
    req_addr[0 +: AW] = 32'h0000_0040;
    req_read[0]       = 1'b1;
    req_write[0]      = 1'b1;
    @(negedge clk);
    check("t4_read_priority", {mem_read, mem_write}, 2'b10);
    wait_resp(0, "t4_resp");
    req_read[0]  = 1'b0;
    req_write[0] = 1'b0;

    // Spurious mem_resp while idle.
    mem_auto = 1'b0;
    repeat (2) @(negedge clk);
    #1 mem_resp = 1'b1;
    @(negedge clk);
    #1 mem_resp = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_spurious_no_resp", {req_resp, grant, mem_read, mem_write}, '0);

    // Reset mid-BUSY on a port 2 read.
    req_addr[2*AW +: AW] = 32'h0000_7700;
    req_read[2]          = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_busy_before_reset", mem_read, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_mem_read_async_drop", {mem_read, mem_write}, 2'b00);
    check("t6_no_resp_grant", {req_resp, grant}, '0);

    // Contention after reset: all three ports reading continuously.
    req_addr  = {32'h0000_A200, 32'h0000_A100, 32'h0000_A000};
    req_read  = 3'b111;
    mem_auto  = 1'b1;
    resp_lat  = 0;
    repeat (2) @(negedge clk);
    grant_log.delete();
    #2 rst_n = 1'b1;
    for (int k = 0; k < 300 && grant_log.size() < 6; k++) @(negedge clk);
    check("t7_six_grants", grant_log.size() >= 6, 1'b1);
    for (int k = 0; k < 6 && k < grant_log.size(); k++) begin
      logic [NP-1:0] exp_g;
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp_g = 3'b001;
`else
      exp_g = NP'(1) << (k % NP);
`endif
      check($sformatf("t7_grant_order_%0d", k), grant_log[k], exp_g);
    end
    req_read = '0;
    repeat (20) @(negedge clk);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < NP; i++) begin
        if (active[i] && req_resp[i]) begin
          active[i]    = 1'b0;
          req_read[i]  = 1'b0;
          req_write[i] = 1'b0;
        end else if (!active[i] && $urandom_range(0, 3) == 0) begin
          int op;
          op = $urandom_range(0, 2);
          active[i]            = 1'b1;
          req_read[i]          = (op != 1);
          req_write[i]         = (op != 0);
          req_addr[i*AW +: AW] = {$urandom_range(0, 32'hFFFF), 6'b0, 10'b0};
          req_wdata[i*LW +: LW] = {8{$urandom()}};
        end else if (active[i] && grant[i] && $urandom_range(0, 7) == 0) begin
          req_addr[i*AW +: AW]  = $urandom();
          req_wdata[i*LW +: LW] = {8{$urandom()}};
          if ($urandom_range(0, 3) == 0) begin
            req_read[i]  = 1'b0;
            req_write[i] = 1'b0;
          end
        end
      end
    end

    // Drain outstanding requests.
    for (int k = 0; k < 200 && active != '0; k++) begin
      @(negedge clk);
      for (int i = 0; i < NP; i++) begin
        if (active[i] && req_resp[i]) begin
          active[i]    = 1'b0;
          req_read[i]  = 1'b0;
          req_write[i] = 1'b0;
        end
      end
    end
    check("drain_all_served", active, '0);
    repeat (5) @(negedge clk);
    check("drain_scoreboard_empty", sb.size(), 0);
    check("drain_idle", {grant, mem_read, mem_write}, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
